gnrl_iqcomb_decimator: RTL and testbench



---
 rtl/gnrl_iqcomb_decimator_pkg.sv | 11 +
 rtl/iq_accum_channel.sv | 20 ++
 rtl/gnrl_iqcomb_decimator.sv | 75 +++++++
 tb/tb_gnrl_iqcomb_decimator.sv | 135 +++++++++++++
 4 files changed

// File: rtl/gnrl_iqcomb_decimator_pkg.sv
// Shared constants and types for the I/Q integrate-and-dump decimator.
package gnrl_iqcomb_decimator_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int DEC_WIDTH_DEF  = 16;
   localparam int MIN_DEC        = 2;

   typedef enum logic {
      PH_IDLE = 1'b0,
      PH_Q    = 1'b1
   } phase_t;
endpackage

// File: rtl/iq_accum_channel.sv
// One integrate-and-dump accumulator; sum is the running total including the current input.
module iq_accum_channel #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  dump,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] sum
);
   logic [DATA_WIDTH-1:0] acc;

   assign sum = acc + din;

   always_ff @(posedge clk) begin
      if (reset)   acc <= '0;
      else if (en) acc <= dump ? '0 : sum;
   end
endmodule

// File: rtl/gnrl_iqcomb_decimator.sv
// Sums Neff valid I/Q samples and emits the I sum then the Q sum on one shared bus.
module gnrl_iqcomb_decimator
   import gnrl_iqcomb_decimator_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEC_WIDTH  = DEC_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] dataI,
   input  logic [DATA_WIDTH-1:0] dataQ,
   input  logic                  in_valid,
   input  logic [DEC_WIDTH-1:0]  dec_fact,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic                  out_valid
);
   localparam logic [DEC_WIDTH-1:0] MIN_N = DEC_WIDTH'(MIN_DEC);

   logic [DEC_WIDTH-1:0]  cnt, n_lat, n_new, n_eff;
   logic [DEC_WIDTH:0]    cnt_inc;
   logic                  last;
   logic [DATA_WIDTH-1:0] i_sum, q_sum, qhold;
   phase_t                phase, phase_nxt;

   // The first sample of a block uses the live factor; later samples use the latched copy.
   assign n_new   = (dec_fact < MIN_N) ? MIN_N : dec_fact;
   assign n_eff   = (cnt == '0) ? n_new : n_lat;
   assign cnt_inc = {1'b0, cnt} + (DEC_WIDTH+1)'(1);
   assign last    = in_valid && (cnt_inc == {1'b0, n_eff});

   iq_accum_channel #(.DATA_WIDTH(DATA_WIDTH)) u_acc_i (
      .clk(CLK), .reset(RESET), .en(in_valid), .dump(last), .din(dataI), .sum(i_sum)
   );
   iq_accum_channel #(.DATA_WIDTH(DATA_WIDTH)) u_acc_q (
      .clk(CLK), .reset(RESET), .en(in_valid), .dump(last), .din(dataQ), .sum(q_sum)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt   <= '0;
         n_lat <= MIN_N;
      end else if (in_valid) begin
         cnt <= last ? '0 : cnt_inc[DEC_WIDTH-1:0];
         if (cnt == '0) n_lat <= n_new;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) phase <= PH_IDLE;
      else       phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = PH_IDLE;
      if (last) phase_nxt = PH_Q;
   end

   // Neff >= 2 guarantees a dump never lands in the Q slot.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         dataout   <= '0;
         out_valid <= 1'b0;
         qhold     <= '0;
      end else if (last) begin
         dataout   <= i_sum;
         qhold     <= q_sum;
         out_valid <= 1'b1;
      end else if (phase == PH_Q) begin
         dataout   <= qhold;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_gnrl_iqcomb_decimator.sv
module tb_gnrl_iqcomb_decimator;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] dataI, dataQ;
  logic        in_valid;
  logic [15:0] dec_fact;
  logic [31:0] dataout;
  logic        out_valid;

  gnrl_iqcomb_decimator #(.DATA_WIDTH(32), .DEC_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .dataI(dataI), .dataQ(dataQ), .in_valid(in_valid),
    .dec_fact(dec_fact), .dataout(dataout), .out_valid(out_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] dec;
    logic [31:0] di;
    logic [31:0] dq;
    logic        ov;
    logic [31:0] dout;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  task automatic add(input logic rst, input logic vld, input logic [15:0] dec,
                     input logic [31:0] di, input logic [31:0] dq,
                     input logic ov, input logic [31:0] dout, input string tag);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dec = dec; v.di = di; v.dq = dq;
    v.ov = ov; v.dout = dout; v.tag = tag;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: wait expired after %0d of %0d vectors", applied, vecs.size());
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
    end
  end

  initial begin
    add(1, 0, 16, 0, 0, 0, 0, "reset0");
    add(1, 0, 16, 0, 0, 0, 0, "reset1");

    for (int k = 1; k <= 66; k++) begin
      if (k % 16 == 0)               add(0, 1, 16, 100, 200, 1, 1600, "n16_isum");
      else if (k % 16 == 1 && k > 1) add(0, 1, 16, 100, 200, 1, 3200, "n16_qsum");
      else add(0, 1, 16, 100, 200, 0, (k < 16) ? 32'd0 : 32'd3200, "n16_quiet");
    end

    for (int k = 0; k < 50; k++) add(0, 0, 16, 'x, 'x, 0, 3200, "gap_hold");
    for (int k = 1; k <= 14; k++)
      add(0, 1, 16, 100, 200, (k == 14), (k == 14) ? 32'd1600 : 32'd3200, "gap_resume");
    add(0, 0, 16, 0, 0, 1, 3200, "gap_qsum");
    add(0, 0, 16, 0, 0, 0, 3200, "gap_after");

    for (int m = 1; m <= 8; m++) begin
      if (m == 1)          add(0, 1, 1, 5, 7, 0, 3200, "n1_first");
      else if (m % 2 == 0) add(0, 1, 1, 5, 7, 1, 10, "n1_isum");
      else                 add(0, 1, 1, 5, 7, 1, 14, "n1_qsum");
    end
    add(0, 0, 1, 0, 0, 1, 14, "n1_lastq");
    add(0, 0, 1, 0, 0, 0, 14, "n1_idle");

    add(0, 1, 2, 32'h8000_0000, 1, 0, 14, "wrap_s1");
    add(0, 1, 2, 32'h8000_0000, 1, 1, 32'h0000_0000, "wrap_isum");
    add(0, 0, 2, 0, 0, 1, 2, "wrap_qsum");
    add(0, 0, 2, 0, 0, 0, 2, "wrap_idle");

    add(0, 1, 4, 1, 2, 0, 2, "chg_s1");
    add(0, 1, 8, 1, 2, 0, 2, "chg_s2");
    add(0, 1, 8, 1, 2, 0, 2, "chg_s3");
    add(0, 1, 8, 1, 2, 1, 4, "chg_dump4");
    add(0, 1, 8, 1, 2, 1, 8, "chg_q4");
    for (int k = 2; k <= 7; k++) add(0, 1, 3, 1, 2, 0, 8, "chg_n8_run");
    add(0, 1, 3, 1, 2, 1, 8, "chg_dump8");
    add(0, 0, 3, 0, 0, 1, 16, "chg_q8");
    add(0, 0, 3, 0, 0, 0, 16, "chg_idle");

    for (int k = 1; k <= 10; k++) add(0, 1, 16, 3, 4, 0, 16, "rst_pre");
    add(1, 1, 16, 3, 4, 0, 0, "rst_mid");
    for (int k = 1; k <= 16; k++)
      add(0, 1, 16, 3, 4, (k == 16), (k == 16) ? 32'd48 : 32'd0, "rst_fresh");
    add(0, 0, 16, 0, 0, 1, 64, "rst_qsum");
    add(0, 0, 16, 0, 0, 0, 64, "rst_idle");

    add(0, 1, 2, 9, 11, 0, 64, "rstq_s1");
    add(0, 1, 2, 9, 11, 1, 18, "rstq_isum");
    add(1, 0, 2, 0, 0, 0, 0, "rstq_reset");
    add(0, 0, 2, 0, 0, 0, 0, "rstq_noq");

    RESET = 1'b1; in_valid = 1'b0; dec_fact = 16; dataI = '0; dataQ = '0;
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge CLK);
      RESET    = vecs[n].rst;
      in_valid = vecs[n].vld;
      dec_fact = vecs[n].dec;
      dataI    = vecs[n].di;
      dataQ    = vecs[n].dq;
      @(posedge CLK);
      #1;
      applied++;
      if (out_valid !== vecs[n].ov || dataout !== vecs[n].dout) begin
        miscompares++;
        $display("FAIL vec[%0d] %s: got out_valid=%b dataout=0x%08h, want out_valid=%b dataout=0x%08h",
                 n, vecs[n].tag, out_valid, dataout, vecs[n].ov, vecs[n].dout);
      end
      if (n == 1) begin
        if (out_valid !== 1'b0 || dataout !== 32'd0) begin
          miscompares++;
          $display("FAIL reset state: out_valid=%b dataout=0x%08h, want 0/0", out_valid, dataout);
        end
      end
    end

    done = 1'b1;
    if (applied != vecs.size()) begin
      miscompares++;
      $display("FAIL only %0d of %0d vectors applied", applied, vecs.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
